serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor to the single-bit half/full adder cells.
- Adds two WIDTH-bit operands DIGIT bits per clock, using a registered carry between digits.
- Uses a start/busy/done handshake and returns sum, carry-out and signed overflow.
- Sits beside the ALU as a small-area arithmetic unit built from the existing gate-level adder cells.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_digit.sv | 44 ++++
 rtl/serial_adder.sv | 152 +++++++++++++++
 tb/tb_serial_adder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helpers for multi-cycle arithmetic units
//
// Purpose: common FSM state type and counter sizing used by serial_adder and
//          by later digit-serial multiplier/divider blocks.
// Contents:
//   state_t       - ST_IDLE / ST_RUN / ST_DONE
//   cnt_width(n)  - bits needed to count 0..n
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// rtl/serial_adder_digit.sv - combinational DIGIT-bit ripple adder built from half-adder pairs
//
// Purpose: adds one digit of each operand plus a carry-in.
// Ports:
//   i_a_d   [DIGIT] - digit of operand A
//   i_b_d   [DIGIT] - digit of operand B
//   i_ci            - carry into bit 0 of the digit
//   o_s_d   [DIGIT] - digit sum
//   o_co            - carry out of the top bit of the digit
//   o_c_msb         - carry into the top bit of the digit (signed overflow detection)
module serial_adder_digit
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a_d,
    input  logic [DIGIT-1:0] i_b_d,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_s_d,
    output logic             o_co,
    output logic             o_c_msb
);

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_p;
    logic [DIGIT-1:0] w_g1;
    logic [DIGIT-1:0] w_g2;

    assign w_c[0] = i_ci;

    // Each full adder is two half adders: (a,b) then (partial sum, carry-in);
    // the two half-adder carries are mutually exclusive, so OR merges them.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign w_p[i]    = i_a_d[i] ^ i_b_d[i];
        assign w_g1[i]   = i_a_d[i] & i_b_d[i];
        assign o_s_d[i]  = w_p[i] ^ w_c[i];
        assign w_g2[i]   = w_p[i] & w_c[i];
        assign w_c[i+1]  = w_g1[i] | w_g2[i];
    end

    assign o_co    = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor with start/busy/done handshake
//
// Purpose: adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock.
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_start          - request, accepted only in IDLE
//   i_a, i_b [WIDTH] - operands, sampled on the accept edge
//   i_cin            - carry-in for add (ignored for subtract)
//   i_sub            - 0: a+b+cin, 1: a-b
//   o_busy           - high while the operation runs
//   o_done           - one-cycle pulse when the result becomes valid
//   o_sum  [WIDTH]   - result, held until the next accept
//   o_cout           - carry out of the MSB (subtract: 1 = no borrow)
//   o_ovf            - signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic [DIGIT-1:0]  w_s_d;
    logic              w_co;
    logic              w_c_msb;
    logic [WIDTH-1:0]  w_sum_shift;
    logic [WIDTH-1:0]  w_a_shift;
    logic [WIDTH-1:0]  w_b_shift;

    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_last   = (r_cnt == CW'(N - 1));

    serial_adder_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a_d   (r_a[DIGIT-1:0]),
        .i_b_d   (r_b[DIGIT-1:0]),
        .i_ci    (r_carry),
        .o_s_d   (w_s_d),
        .o_co    (w_co),
        .o_c_msb (w_c_msb)
    );

    // Result digits enter at the MSB end so the first (least significant)
    // digit has walked down to bit 0 after N shifts.
    if (N > 1) begin : g_multi
        assign w_sum_shift = {w_s_d, r_sum[WIDTH-1:DIGIT]};
        assign w_a_shift   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
        assign w_b_shift   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign w_sum_shift = w_s_d;
        assign w_a_shift   = '0;
        assign w_b_shift   = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            // Subtract is a + ~b + 1: invert B once here and seed the carry.
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= w_sum_shift;
            r_a     <= w_a_shift;
            r_b     <= w_b_shift;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_c_msb ^ w_co;
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (8x1, 16x4, 8x8 configurations)
module tb_serial_adder;

    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [7:0]  sum0;
    logic [15:0] sum1;
    logic [7:0]  sum2;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_a(a[7:0]), .i_b(b[7:0]),
        .i_cin(cin), .i_sub(sub), .o_busy(busy[0]), .o_done(done[0]), .o_sum(sum0),
        .o_cout(cout[0]), .o_ovf(ovf[0])
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_a(a), .i_b(b),
        .i_cin(cin), .i_sub(sub), .o_busy(busy[1]), .o_done(done[1]), .o_sum(sum1),
        .o_cout(cout[1]), .o_ovf(ovf[1])
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_a(a[7:0]), .i_b(b[7:0]),
        .i_cin(cin), .i_sub(sub), .o_busy(busy[2]), .o_done(done[2]), .o_sum(sum2),
        .o_cout(cout[2]), .o_ovf(ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int w_of(input int k);
        return (k == 1) ? 16 : 8;
    endfunction

    function automatic int n_of(input int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : 1;
    endfunction

    function automatic logic [15:0] get_sum(input int k);
        case (k)
            0:       return {8'h00, sum0};
            1:       return sum1;
            default: return {8'h00, sum2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow.
    task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb,
                         output logic [15:0] s, output logic co, output logic ov);
        longint m, ua, ub, sa, sbv, u, r;
        m   = longint'(1) << w;
        ua  = longint'(av) % m;
        ub  = longint'(bv) % m;
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        if (sb) begin
            u  = ua - ub;
            co = (ua >= ub);
            r  = sa - sbv;
        end else begin
            u  = ua + ub + longint'(ci);
            co = (u >= m);
            r  = sa + sbv + longint'(ci);
        end
        s  = 16'(((u % m) + m) % m);
        ov = (r >= m / 2) || (r < -(m / 2));
    endtask

    task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input bit jitter);
        logic [15:0] es;
        logic        ec, eo;
        int          lat, nbusy;
        bit          got;
        model(w_of(k), av, bv, ci, sb, es, ec, eo);
        a = av; b = bv; cin = ci; sub = sb;
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        chk($sformatf("u%0d busy_after_accept", k), 32'(busy[k]), 32'd1);
        lat = 0; nbusy = 0; got = 0;
        while (!got && lat < 40) begin
            if (busy[k]) nbusy++;
            if (jitter) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            if (done[k]) got = 1;
        end
        chk($sformatf("u%0d latency a=%0h b=%0h", k, av, bv), 32'(lat), 32'(n_of(k)));
        chk($sformatf("u%0d busy_cycles", k), 32'(nbusy), 32'(n_of(k)));
        chk($sformatf("u%0d sum a=%0h b=%0h ci=%0d sub=%0d", k, av, bv, ci, sb), 32'(get_sum(k)), 32'(es));
        chk($sformatf("u%0d cout a=%0h b=%0h sub=%0d", k, av, bv, sb), 32'(cout[k]), 32'(ec));
        chk($sformatf("u%0d ovf a=%0h b=%0h sub=%0d", k, av, bv, sb), 32'(ovf[k]), 32'(eo));
        @(posedge clk); #1;
        chk($sformatf("u%0d done_one_cycle", k), 32'(done[k]), 32'd0);
        chk($sformatf("u%0d sum_held", k), 32'(get_sum(k)), 32'(es));
    endtask

    initial begin
        logic [15:0] es;
        logic        ec, eo;
        int          lat, ndone;
        bit          got;

        rst = 1'b1; start = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d reset_busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("u%0d reset_done", k), 32'(done[k]), 32'd0);
            chk($sformatf("u%0d reset_sum", k), 32'(get_sum(k)), 32'd0);
            chk($sformatf("u%0d reset_cout_ovf", k), 32'({cout[k], ovf[k]}), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        do_op(0, 16'h003C, 16'h0045, 1'b0, 1'b0, 1'b0);
        chk("u0 plan_3c_45_sum", 32'(sum0), 32'h81);
        do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(0, 16'h007F, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        do_op(0, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0);
        do_op(1, 16'h1234, 16'hEDCC, 1'b0, 1'b0, 1'b0);
        chk("u1 plan_1234_edcc_cout", 32'(cout[1]), 32'd1);
        do_op(2, 16'h003C, 16'h0045, 1'b0, 1'b0, 1'b0);
        do_op(2, 16'h0080, 16'h0001, 1'b0, 1'b1, 1'b0);

        // Random operations; operand inputs are scrambled while each op runs.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                do_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end
        end

        // Start re-asserted mid-run and held through DONE.
        a = 16'h003C; b = 16'h0045; cin = 1'b0; sub = 1'b0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        a = 16'h0010; b = 16'h0020;
        start[0] = 1'b1;
        lat = 3; got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done[0]) got = 1;
        end
        chk("restart first_latency", 32'(lat), 32'd8);
        chk("restart first_sum", 32'(sum0), 32'h81);
        chk("restart first_ovf", 32'(ovf[0]), 32'd1);
        @(posedge clk); #1;
        chk("restart idle_done", 32'(done[0]), 32'd0);
        chk("restart idle_busy", 32'(busy[0]), 32'd0);
        chk("restart idle_sum_held", 32'(sum0), 32'h81);
        @(posedge clk); #1;
        chk("restart second_accepted", 32'(busy[0]), 32'd1);
        start[0] = 1'b0;
        model(8, 16'h0010, 16'h0020, 1'b0, 1'b0, es, ec, eo);
        lat = 0; got = 0; ndone = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done[0]) got = 1;
        end
        chk("restart second_latency", 32'(lat), 32'd8);
        chk("restart second_sum", 32'(sum0), 32'(es[7:0]));
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            if (done[0]) ndone++;
            @(posedge clk); #1;
        end
        chk("restart no_extra_done", 32'(ndone), 32'd0);

        // Asynchronous reset in the middle of an operation.
        a = 16'h005A; b = 16'h0033; cin = 1'b0; sub = 1'b0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy[0]), 32'd0);
        chk("abort done", 32'(done[0]), 32'd0);
        chk("abort sum", 32'(sum0), 32'd0);
        chk("abort cout_ovf", 32'({cout[0], ovf[0]}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done[0] || busy[0]) ndone++;
        end
        chk("abort no_done_after", 32'(ndone), 32'd0);
        do_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("abort fresh_sum", 32'(sum0), 32'h02);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
